// File: rtl/key_autorepeat_pkg.sv
// -----------------------------------------------------------------------------
// key_autorepeat_pkg
// Shared types and helpers for the key auto-repeat generator.
//   ar_state_t    : FSM state encoding.
//   ar_flags_t    : status outputs decoded from a state.
//   ns_to_cycles  : converts an interval in ns to whole clock cycles.
//   state_flags   : status flags that belong to a given state.
// -----------------------------------------------------------------------------
package key_autorepeat_pkg;

  typedef enum logic [2:0] {
    Idle,
    Pause,
    Repeat,
    Fast,
    Hold
  } ar_state_t;

  typedef struct packed {
    logic held;
    logic repeating;
    logic fast;
  } ar_flags_t;

  function automatic longint ns_to_cycles(input longint ns, input longint period);
    return ns / period;
  endfunction

  function automatic ar_flags_t state_flags(input ar_state_t s);
    ar_flags_t f;
    f.held      = (s != Idle);
    f.repeating = (s == Repeat) || (s == Fast);
    f.fast      = (s == Fast);
    return f;
  endfunction

endpackage

// File: rtl/key_autorepeat_if.sv
// -----------------------------------------------------------------------------
// key_autorepeat_if
// Groups the key inputs and event/status outputs of key_autorepeat.
// Signal suffixes are from the generator's point of view.
//   keys_i      : raw active-low key lines (0 = pressed), asynchronous.
//   pulse_o     : one-clock active-high pulse per key event, per channel.
//   held_o      : FSM not Idle.
//   repeating_o : FSM in Repeat or Fast.
//   fast_o      : FSM in Fast.
// Modports: slave = the generator, master = whoever drives the keys.
// -----------------------------------------------------------------------------
interface key_autorepeat_if #(
  parameter int Channels = 3
);
  logic [Channels-1:0] keys_i;
  logic [Channels-1:0] pulse_o;
  logic                held_o;
  logic                repeating_o;
  logic                fast_o;

  modport slave (
    input  keys_i,
    output pulse_o, held_o, repeating_o, fast_o
  );

  modport master (
    output keys_i,
    input  pulse_o, held_o, repeating_o, fast_o
  );
endinterface

// File: rtl/key_autorepeat_sync.sv
// -----------------------------------------------------------------------------
// key_sync
// Width-parametrised two-flop synchroniser with a configurable reset value.
//   clk   : destination clock.
//   rst_n : synchronous active-low reset, loads ResetValue into both stages.
//   d_i   : asynchronous input bits.
//   q_o   : synchronised bits, two clocks of latency.
// -----------------------------------------------------------------------------
module key_sync #(
  parameter int   Width      = 1,
  parameter logic ResetValue = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and the two stages stay a real pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= {Width{ResetValue}};
      sync_q <= {Width{ResetValue}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_autorepeat.sv
// -----------------------------------------------------------------------------
// key_autorepeat
// N-channel auto-repeat generator for active-low buttons. Emits one pulse per
// pressed key on press, then repeat pulses after a pause, at a slow rate and,
// after FastAfter repeats, at a fast rate while the same key set stays held.
// A change of key set restarts the sequence with a fresh press pulse.
//   Clock  : single clock, rising edge.
//   nReset : synchronous active-low reset.
//   bus    : key_autorepeat_if slave (keys_i in; pulse_o, held_o,
//            repeating_o, fast_o out). All outputs are registered.
// -----------------------------------------------------------------------------
module key_autorepeat
  import key_autorepeat_pkg::*;
#(
  parameter int            Channels          = 3,
  parameter longint        ClockPeriod_ns    = 20,
  parameter longint        PauseInterval_ns  = 250_000_000,
  parameter longint        RepeatInterval_ns = 150_000_000,
  parameter longint        FastInterval_ns   = 50_000_000,
  parameter int            FastAfter         = 8,
  parameter [Channels-1:0] RepeatMask        = '1
) (
  input  logic             Clock,
  input  logic             nReset,
  key_autorepeat_if.slave  bus
);

  localparam longint MaxPause  = ns_to_cycles(PauseInterval_ns, ClockPeriod_ns);
  localparam longint MaxRepeat = ns_to_cycles(RepeatInterval_ns, ClockPeriod_ns);
  localparam longint MaxFast   = ns_to_cycles(FastInterval_ns, ClockPeriod_ns);
  localparam longint MaxPR     = (MaxPause > MaxRepeat) ? MaxPause : MaxRepeat;
  localparam longint MaxAll    = (MaxPR > MaxFast) ? MaxPR : MaxFast;
  localparam int     CW        = $clog2(MaxAll + 1);
  localparam int     RW        = $clog2(FastAfter + 1);

  localparam logic [CW-1:0] PauseLast  = CW'(MaxPause - 1);
  localparam logic [CW-1:0] RepeatLast = CW'(MaxRepeat - 1);
  localparam logic [CW-1:0] FastLast   = CW'(MaxFast - 1);
  localparam logic [RW-1:0] FastCount  = RW'(FastAfter);

  // A terminal count below 1 would make the counter compare meaningless.
  if (MaxPause < 2 || MaxRepeat < 2 || MaxFast < 2 || FastAfter < 1) begin : g_bad_params
    $error("key_autorepeat: intervals must be >= 2 clocks and FastAfter >= 1");
  end

  logic [Channels-1:0] keys_sync;
  logic [Channels-1:0] k;          // active-high view of the keys
  logic [Channels-1:0] rep_set;    // channels allowed to repeat in this chord
  logic [RW-1:0]       rcount_d;   // saturating next repeat count

  ar_state_t           state_q;
  ar_flags_t           flags_q;
  logic [Channels-1:0] chord_q;
  logic [Channels-1:0] pulse_q;
  logic [CW-1:0]       counter_q;
  logic [RW-1:0]       rcount_q;

  key_sync #(
    .Width      (Channels),
    .ResetValue (1'b1)
  ) u_sync (
    .clk   (Clock),
    .rst_n (nReset),
    .d_i   (bus.keys_i),
    .q_o   (keys_sync)
  );

  assign k        = ~keys_sync;
  assign rep_set  = chord_q & RepeatMask;
  assign rcount_d = (rcount_q == FastCount) ? rcount_q : rcount_q + RW'(1);

  // Status flags are registered together with the state so they change on
  // the same edge as the transition.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q   <= Idle;
      flags_q   <= '0;
      chord_q   <= '0;
      pulse_q   <= '0;
      counter_q <= '0;
      rcount_q  <= '0;
    end else begin
      pulse_q <= '0;
      if (state_q == Idle) begin
        if (k != '0) begin
          pulse_q   <= k;
          chord_q   <= k;
          counter_q <= '0;
          state_q   <= Pause;
          flags_q   <= state_flags(Pause);
        end
      end else if (k == '0) begin
        // Release wins over any repeat that would fall due on this edge.
        counter_q <= '0;
        rcount_q  <= '0;
        state_q   <= Idle;
        flags_q   <= state_flags(Idle);
      end else if (k != chord_q) begin
        pulse_q   <= k;
        chord_q   <= k;
        counter_q <= '0;
        rcount_q  <= '0;
        state_q   <= Pause;
        flags_q   <= state_flags(Pause);
      end else begin
        unique case (state_q)
          Pause: begin
            if (counter_q == PauseLast) begin
              counter_q <= '0;
              if (rep_set != '0) begin
                pulse_q  <= rep_set;
                rcount_q <= RW'(1);
                if (FastAfter == 1) begin
                  state_q <= Fast;
                  flags_q <= state_flags(Fast);
                end else begin
                  state_q <= Repeat;
                  flags_q <= state_flags(Repeat);
                end
              end else begin
                // Only masked keys held: stay quiet until release or change.
                state_q <= Hold;
                flags_q <= state_flags(Hold);
              end
            end else begin
              counter_q <= counter_q + CW'(1);
            end
          end
          Repeat: begin
            if (counter_q == RepeatLast) begin
              pulse_q   <= rep_set;
              counter_q <= '0;
              rcount_q  <= rcount_d;
              if (rcount_d == FastCount) begin
                state_q <= Fast;
                flags_q <= state_flags(Fast);
              end
            end else begin
              counter_q <= counter_q + CW'(1);
            end
          end
          Fast: begin
            if (counter_q == FastLast) begin
              pulse_q   <= rep_set;
              counter_q <= '0;
            end else begin
              counter_q <= counter_q + CW'(1);
            end
          end
          Hold: begin
          end
          default: begin
            state_q <= Idle;
            flags_q <= state_flags(Idle);
          end
        endcase
      end
    end
  end

  assign bus.pulse_o     = pulse_q;
  assign bus.held_o      = flags_q.held;
  assign bus.repeating_o = flags_q.repeating;
  assign bus.fast_o      = flags_q.fast;

endmodule
